aead_stream_framer: RTL and testbench

- Host-side initiator for chacha20_poly1305_core.
- Takes a byte-counted message (AAD bytes followed by payload bytes, both as 128-bit beats) and drives the core's aad, pld and len channels with correct keep masks.
- Requests keystream blocks from the core, XORs each payload beat with the matching 128-bit lane, and returns the result to the host.
- Supports both encrypt and decrypt; in both cases Poly1305 sees the ciphertext.

---
 rtl/aead_stream_framer_if.sv | 52 +++++
 rtl/aead_stream_framer.sv | 190 +++++++++++++++++++
 tb/tb_aead_stream_framer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aead_stream_framer_if.sv
// Bundle of host, keystream and core-channel signals around the AEAD framer.
// Latency: none, wires only.
// Backpressure: valid/ready pairs. Each valid is held with stable data until its ready is seen.
interface aead_stream_framer_if #(
  parameter int LEN_W = 32
);
  logic             start;
  logic [LEN_W-1:0] aad_bytes;
  logic [LEN_W-1:0] pld_bytes;
  logic             dec;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [15:0]      out_keep;
  logic             ks_req;
  logic             ks_valid;
  logic [511:0]     ks_data;
  logic             aad_valid;
  logic             aad_ready;
  logic [127:0]     aad_data;
  logic [15:0]      aad_keep;
  logic             pld_valid;
  logic             pld_ready;
  logic [127:0]     pld_data;
  logic [15:0]      pld_keep;
  logic             len_valid;
  logic             len_ready;
  logic [127:0]     len_block;

  // Framer side: it initiates every transfer toward the core.
  modport master (
    input  start, aad_bytes, pld_bytes, dec, in_valid, in_data, out_ready,
           ks_valid, ks_data, aad_ready, pld_ready, len_ready,
    output busy, done, in_ready, out_valid, out_data, out_keep, ks_req,
           aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
           len_valid, len_block
  );

  // Host and core side.
  modport slave (
    output start, aad_bytes, pld_bytes, dec, in_valid, in_data, out_ready,
           ks_valid, ks_data, aad_ready, pld_ready, len_ready,
    input  busy, done, in_ready, out_valid, out_data, out_keep, ks_req,
           aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
           len_valid, len_block
  );
endinterface

// File: rtl/aead_stream_framer.sv
// Frames a byte-counted AAD+payload message into core aad/pld/len beats and XORs the payload with keystream.
// Latency: 1 cycle from an in handshake to aad or pld/out valid; ks_req 1 cycle after the final AAD handoff.
// Backpressure: in_ready is withheld until the downstream output registers are free. Valids hold until ready.
module aead_stream_framer #(
  parameter int LEN_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  aead_stream_framer_if.master bus
);
  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [2:0] {IDLE, AAD, KS_REQ, KS_WAIT, PLD, LEN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] aad_len, pld_len;
  logic             dec_r;
  logic [CNT_W-1:0] aad_cnt, pld_cnt;
  logic [CNT_W-1:0] n_a, n_p;
  logic [511:0]     ks_r;
  logic [1:0]       lane;
  logic             aad_vld_q, pld_vld_q, out_vld_q;
  logic [127:0]     aad_dat_q, pld_dat_q, out_dat_q;
  logic [15:0]      aad_keep_q, pld_keep_q, out_keep_q;
  logic             aad_acc, pld_acc;
  logic [15:0]      keep_a, keep_p;
  logic [127:0]     lane_dat, in_aad, in_pt, in_ct;

  // Number of 128-bit beats needed for a byte count.
  function automatic logic [CNT_W-1:0] beats(input logic [LEN_W-1:0] b);
    return CNT_W'(b >> 4) + CNT_W'(|b[3:0]);
  endfunction

  // Keep mask for beat idx of n. Only the last beat can be partial.
  function automatic logic [15:0] keep_of(input logic [CNT_W-1:0] idx,
                                          input logic [CNT_W-1:0] n,
                                          input logic [LEN_W-1:0] b);
    if ((idx == n - CNT_W'(1)) && (b[3:0] != 4'd0))
      return (16'd1 << b[3:0]) - 16'd1;
    return 16'hFFFF;
  endfunction

  // Expand byte-enable bits to a 128-bit data mask.
  function automatic logic [127:0] byte_mask(input logic [15:0] k);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign n_a      = beats(aad_len);
  assign n_p      = beats(pld_len);
  assign keep_a   = keep_of(aad_cnt, n_a, aad_len);
  assign keep_p   = keep_of(pld_cnt, n_p, pld_len);
  assign lane_dat = ks_r[{lane, 7'd0} +: 128];
  assign in_aad   = bus.in_data & byte_mask(keep_a);
  assign in_pt    = bus.in_data & byte_mask(keep_p);
  assign in_ct    = (bus.in_data ^ lane_dat) & byte_mask(keep_p);

  assign bus.aad_valid = aad_vld_q;
  assign bus.aad_data  = aad_dat_q;
  assign bus.aad_keep  = aad_keep_q;
  assign bus.pld_valid = pld_vld_q;
  assign bus.pld_data  = pld_dat_q;
  assign bus.pld_keep  = pld_keep_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.out_keep  = out_keep_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the handshake and strobe outputs decoded from state.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.ks_req    = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state != IDLE) && (state != DONE);
    bus.len_valid = 1'b0;
    bus.len_block = '0;
    aad_acc       = 1'b0;
    pld_acc       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.aad_bytes != '0)      state_nxt = AAD;
          else if (bus.pld_bytes != '0) state_nxt = KS_REQ;
          else                          state_nxt = LEN;
        end
      end
      AAD: begin
        bus.in_ready = (aad_cnt < n_a) && (!aad_vld_q || bus.aad_ready);
        aad_acc      = bus.in_ready && bus.in_valid;
        if ((aad_cnt == n_a) && aad_vld_q && bus.aad_ready)
          state_nxt = (n_p != '0) ? KS_REQ : LEN;
      end
      KS_REQ: begin
        bus.ks_req = 1'b1;
        state_nxt  = KS_WAIT;
      end
      KS_WAIT: begin
        if (bus.ks_valid) state_nxt = PLD;
      end
      PLD: begin
        if (pld_cnt < n_p) begin
          bus.in_ready = (!out_vld_q || bus.out_ready) && (!pld_vld_q || bus.pld_ready);
          pld_acc      = bus.in_ready && bus.in_valid;
          // The last lane is used up but beats remain, so fetch the next block.
          if (pld_acc && (lane == 2'd3) && (pld_cnt + CNT_W'(1) < n_p))
            state_nxt = KS_REQ;
        end else if (!out_vld_q && !pld_vld_q) begin
          state_nxt = LEN;
        end
      end
      LEN: begin
        bus.len_valid = 1'b1;
        bus.len_block = {64'(pld_len), 64'(aad_len)};
        if (bus.len_ready) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Message context, keystream latch and the aad/pld/out output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_len    <= '0;
      pld_len    <= '0;
      dec_r      <= 1'b0;
      aad_cnt    <= '0;
      pld_cnt    <= '0;
      ks_r       <= '0;
      lane       <= 2'd0;
      aad_vld_q  <= 1'b0;
      aad_dat_q  <= '0;
      aad_keep_q <= '0;
      pld_vld_q  <= 1'b0;
      pld_dat_q  <= '0;
      pld_keep_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
    end else begin
      if ((state == IDLE) && bus.start) begin
        aad_len <= bus.aad_bytes;
        pld_len <= bus.pld_bytes;
        dec_r   <= bus.dec;
        aad_cnt <= '0;
        pld_cnt <= '0;
      end

      if (aad_acc) begin
        aad_dat_q  <= in_aad;
        aad_keep_q <= keep_a;
        aad_vld_q  <= 1'b1;
        aad_cnt    <= aad_cnt + CNT_W'(1);
      end else if (aad_vld_q && bus.aad_ready) begin
        aad_vld_q <= 1'b0;
      end

      if ((state == KS_WAIT) && bus.ks_valid) begin
        ks_r <= bus.ks_data;
        lane <= 2'd0;
      end

      // Poly1305 always sees ciphertext. For decrypt that is the input itself.
      if (pld_acc) begin
        out_dat_q  <= in_ct;
        out_keep_q <= keep_p;
        out_vld_q  <= 1'b1;
        pld_dat_q  <= dec_r ? in_pt : in_ct;
        pld_keep_q <= keep_p;
        pld_vld_q  <= 1'b1;
        lane       <= lane + 2'd1;
        pld_cnt    <= pld_cnt + CNT_W'(1);
      end else begin
        if (out_vld_q && bus.out_ready) out_vld_q <= 1'b0;
        if (pld_vld_q && bus.pld_ready) pld_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aead_stream_framer.sv
// Directed bench for aead_stream_framer: host driver, keystream responder and handshake monitors.
// Latency: expectations are hand-built per scenario.
// Backpressure: readies are driven per scenario, including a pld stall.
module tb_aead_stream_framer;
  logic clk;
  logic rst_n;

  aead_stream_framer_if #(.LEN_W(32)) bus();
  aead_stream_framer #(.LEN_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int           total;
  int           bad;
  logic [143:0] aad_q[$];
  logic [143:0] pld_q[$];
  logic [143:0] out_q[$];
  logic [127:0] len_q[$];
  int           ks_blk;
  int           ks_base;
  int           done_cnt;
  bit           ks_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] in_beat(input int j);
    logic [127:0] base;
    logic [7:0]   b;
    base = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    b    = 8'(j);
    return base ^ {16{b}};
  endfunction

  function automatic logic [127:0] lane_val(input int blk, input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(blk * 256 + k);
    return {w ^ 32'h0F0F0F0F, w, ~w, w + 32'h00001234};
  endfunction

  function automatic logic [511:0] ks_pat(input int blk);
    logic [511:0] r;
    for (int k = 0; k < 4; k++) r[128*k +: 128] = lane_val(blk, k);
    return r;
  endfunction

  function automatic logic [127:0] bmask(input logic [15:0] k);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Record every completed handshake in the low phase, where all signals are settled.
  always @(negedge clk) begin
    if (bus.aad_valid && bus.aad_ready) aad_q.push_back({bus.aad_data, bus.aad_keep});
    if (bus.pld_valid && bus.pld_ready) pld_q.push_back({bus.pld_data, bus.pld_keep});
    if (bus.out_valid && bus.out_ready) out_q.push_back({bus.out_data, bus.out_keep});
    if (bus.len_valid && bus.len_ready) len_q.push_back(bus.len_block);
    if (bus.done) done_cnt++;
  end

  // Keystream responder: answer each ks_req one cycle later with a numbered block.
  initial begin
    int blk;
    bus.ks_valid = 1'b0;
    bus.ks_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.ks_req) begin
        blk = ks_blk - ks_base;
        ks_blk++;
        if (ks_auto) begin
          @(posedge clk); #1;
          bus.ks_valid = 1'b1;
          bus.ks_data  = ks_pat(blk);
          @(posedge clk); #1;
          bus.ks_valid = 1'b0;
        end
      end
    end
  end

  task automatic drive_host(input int n, output bit to);
    int c;
    to = 1'b0;
    for (int j = 0; j < n; j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = in_beat(j);
      c = 0;
      do begin @(negedge clk); c++; end while (!bus.in_ready && c < 300);
      if (!bus.in_ready) begin to = 1'b1; break; end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_done(output int n, output bit to);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 2000);
    to = !bus.done;
  endtask

  // Start one message and run it to done. cyc counts the start cycle as 1.
  task automatic run_msg(input int a, input int p, input bit d, output int cyc, output bit to);
    bit to_h, to_d;
    ks_base       = ks_blk;
    bus.aad_bytes = 32'(a);
    bus.pld_bytes = 32'(p);
    bus.dec       = d;
    bus.start     = 1'b1;
    fork
      begin @(posedge clk); #1; bus.start = 1'b0; end
      drive_host((a + 15) / 16 + (p + 15) / 16, to_h);
      wait_done(cyc, to_d);
    join
    to = to_h | to_d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.busy, bus.done, bus.in_ready, bus.ks_req, bus.aad_valid, bus.pld_valid,
         bus.out_valid, bus.len_valid} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000000", {bus.busy, bus.done, bus.in_ready,
               bus.ks_req, bus.aad_valid, bus.pld_valid, bus.out_valid, bus.len_valid});
    end
    total++;
    if ((bus.aad_data | bus.pld_data | bus.out_data | bus.len_block) !== 128'h0 ||
        {bus.aad_keep, bus.pld_keep, bus.out_keep} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", bus.aad_data | bus.pld_data | bus.out_data | bus.len_block);
    end
  endtask

  task automatic test_long();
    int a0, p0, o0, l0, k0, d0, cyc;
    bit to;
    logic [127:0] exp;
    a0 = aad_q.size(); p0 = pld_q.size(); o0 = out_q.size(); l0 = len_q.size();
    k0 = ks_blk; d0 = done_cnt;
    run_msg(80, 80, 1'b0, cyc, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL long_timeout got=%0b want=0", to); end
    total++;
    if (aad_q.size() - a0 !== 5) begin bad++; $display("FAIL long_aad_count got=%0d want=5", aad_q.size() - a0); end
    for (int i = 0; i < 5 && a0 + i < aad_q.size(); i++) begin
      total++;
      if (aad_q[a0 + i] !== {in_beat(i), 16'hFFFF}) begin
        bad++; $display("FAIL long_aad[%0d] got=%h want=%h", i, aad_q[a0 + i], {in_beat(i), 16'hFFFF});
      end
    end
    total++;
    if (ks_blk - k0 !== 2) begin bad++; $display("FAIL long_ks_req got=%0d want=2", ks_blk - k0); end
    total++;
    if (out_q.size() - o0 !== 5 || pld_q.size() - p0 !== 5) begin
      bad++; $display("FAIL long_pld_count got=%0d/%0d want=5/5", out_q.size() - o0, pld_q.size() - p0);
    end
    for (int i = 0; i < 5 && o0 + i < out_q.size() && p0 + i < pld_q.size(); i++) begin
      exp = in_beat(5 + i) ^ lane_val(i / 4, i % 4);
      total++;
      if (out_q[o0 + i] !== {exp, 16'hFFFF}) begin
        bad++; $display("FAIL long_out[%0d] got=%h want=%h", i, out_q[o0 + i], {exp, 16'hFFFF});
      end
      total++;
      if (pld_q[p0 + i] !== {exp, 16'hFFFF}) begin
        bad++; $display("FAIL long_pld[%0d] got=%h want=%h", i, pld_q[p0 + i], {exp, 16'hFFFF});
      end
    end
    total++;
    if (len_q.size() != l0 + 1 || len_q[len_q.size() - 1] !== 128'h0000000000000050_0000000000000050) begin
      bad++; $display("FAIL long_len got_n=%0d want=00000000000000500000000000000050", len_q.size() - l0);
    end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL long_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_short();
    int a0, p0, o0, k0, cyc;
    bit to;
    logic [127:0] e0, e1;
    a0 = aad_q.size(); p0 = pld_q.size(); o0 = out_q.size(); k0 = ks_blk;
    run_msg(5, 17, 1'b0, cyc, to);
    total++;
    if (to !== 1'b0 || aad_q.size() - a0 !== 1 || pld_q.size() - p0 !== 2 || out_q.size() - o0 !== 2) begin
      bad++; $display("FAIL short_counts got=%0b/%0d/%0d want=0/1/2", to, aad_q.size() - a0, pld_q.size() - p0);
    end else begin
      total++;
      if (aad_q[a0] !== {in_beat(0) & 128'h000000000000000000000000FFFFFFFFFF, 16'h001F}) begin
        bad++; $display("FAIL short_aad got=%h want_keep=001F", aad_q[a0]);
      end
      total++;
      if ((aad_q[a0] >> 56) !== 144'h0) begin bad++; $display("FAIL short_aad_hibytes got=%h want=0", aad_q[a0] >> 56); end
      e0 = in_beat(1) ^ lane_val(0, 0);
      e1 = (in_beat(2) ^ lane_val(0, 1)) & bmask(16'h0001);
      total++;
      if (out_q[o0] !== {e0, 16'hFFFF} || pld_q[p0] !== {e0, 16'hFFFF}) begin
        bad++; $display("FAIL short_beat0 got=%h want=%h", out_q[o0], {e0, 16'hFFFF});
      end
      total++;
      if (out_q[o0 + 1] !== {e1, 16'h0001} || pld_q[p0 + 1] !== {e1, 16'h0001}) begin
        bad++; $display("FAIL short_beat1 got=%h want=%h", out_q[o0 + 1], {e1, 16'h0001});
      end
    end
    total++;
    if (len_q[len_q.size() - 1] !== {64'd17, 64'd5}) begin
      bad++; $display("FAIL short_len got=%h want=%h", len_q[len_q.size() - 1], {64'd17, 64'd5});
    end
    total++;
    if (ks_blk - k0 !== 1) begin bad++; $display("FAIL short_ks_req got=%0d want=1", ks_blk - k0); end
  endtask

  task automatic test_zero();
    int a0, p0, k0, l0, cyc;
    bit to;
    a0 = aad_q.size(); p0 = pld_q.size(); k0 = ks_blk; l0 = len_q.size();
    run_msg(0, 0, 1'b0, cyc, to);
    total++;
    if (to !== 1'b0 || cyc - 1 < 2 || cyc - 1 > 4) begin
      bad++; $display("FAIL zero_latency got=%0d want=2..4", cyc - 1);
    end
    total++;
    if (aad_q.size() != a0 || pld_q.size() != p0 || ks_blk != k0) begin
      bad++; $display("FAIL zero_activity got=%0d/%0d/%0d want=0/0/0", aad_q.size() - a0, pld_q.size() - p0, ks_blk - k0);
    end
    total++;
    if (len_q.size() != l0 + 1 || len_q[len_q.size() - 1] !== 128'h0) begin
      bad++; $display("FAIL zero_len got_n=%0d want=1 block 0", len_q.size() - l0);
    end
  endtask

  task automatic test_dec();
    int p0, o0, cyc;
    bit to;
    p0 = pld_q.size(); o0 = out_q.size();
    run_msg(0, 16, 1'b1, cyc, to);
    total++;
    if (to !== 1'b0 || pld_q.size() - p0 !== 1 || out_q.size() - o0 !== 1) begin
      bad++; $display("FAIL dec_counts got=%0b/%0d want=0/1", to, pld_q.size() - p0);
    end else begin
      total++;
      if (pld_q[p0] !== {in_beat(0), 16'hFFFF}) begin
        bad++; $display("FAIL dec_pld got=%h want=%h", pld_q[p0], {in_beat(0), 16'hFFFF});
      end
      total++;
      if (out_q[o0] !== {in_beat(0) ^ lane_val(0, 0), 16'hFFFF}) begin
        bad++; $display("FAIL dec_out got=%h want=%h", out_q[o0], {in_beat(0) ^ lane_val(0, 0), 16'hFFFF});
      end
    end
  endtask

  task automatic test_backpressure();
    int p0, o0, cyc, c;
    bit to;
    logic [127:0] cap, exp;
    p0 = pld_q.size(); o0 = out_q.size();
    bus.pld_ready = 1'b0;
    fork
      run_msg(0, 48, 1'b0, cyc, to);
      begin
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.pld_valid && c < 100);
        cap = bus.pld_data;
        total++;
        if (cap !== (in_beat(0) ^ lane_val(0, 0))) begin
          bad++; $display("FAIL bp_first got=%h want=%h", cap, in_beat(0) ^ lane_val(0, 0));
        end
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          total++;
          if (bus.pld_valid !== 1'b1 || bus.pld_data !== cap || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_stall[%0d] got=%0b/%h/%0b want=1/%h/0", i, bus.pld_valid, bus.pld_data, bus.in_ready, cap);
          end
        end
        @(posedge clk); #1;
        bus.pld_ready = 1'b1;
      end
    join
    total++;
    if (to !== 1'b0 || pld_q.size() - p0 !== 3 || out_q.size() - o0 !== 3) begin
      bad++; $display("FAIL bp_counts got=%0b/%0d/%0d want=0/3/3", to, pld_q.size() - p0, out_q.size() - o0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = in_beat(i) ^ lane_val(0, i);
        total++;
        if (pld_q[p0 + i] !== {exp, 16'hFFFF} || out_q[o0 + i] !== {exp, 16'hFFFF}) begin
          bad++; $display("FAIL bp_beat[%0d] got=%h want=%h", i, pld_q[p0 + i], {exp, 16'hFFFF});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, o0, k0, cyc;
    bit to;
    logic [127:0] e0, e1;
    ks_auto       = 1'b0;
    bus.aad_bytes = 32'd0;
    bus.pld_bytes = 32'd32;
    bus.dec       = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.ks_req && c < 50);
    total++;
    if (bus.ks_req !== 1'b1) begin bad++; $display("FAIL rstmid_ks_req got=%0b want=1", bus.ks_req); end
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.in_ready, bus.ks_req, bus.aad_valid, bus.pld_valid,
         bus.out_valid, bus.len_valid} !== 8'h00) begin
      bad++; $display("FAIL rstmid_ctrl got=%b want=00000000", {bus.busy, bus.done, bus.in_ready,
                      bus.ks_req, bus.aad_valid, bus.pld_valid, bus.out_valid, bus.len_valid});
    end
    total++;
    if ((bus.aad_data | bus.pld_data | bus.out_data | bus.len_block) !== 128'h0 ||
        {bus.aad_keep, bus.pld_keep, bus.out_keep} !== 48'h0) begin
      bad++; $display("FAIL rstmid_data got=%h want=0", bus.aad_data | bus.pld_data | bus.out_data);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    ks_auto = 1'b1;
    @(posedge clk); #1;
    o0 = out_q.size(); k0 = ks_blk;
    run_msg(0, 32, 1'b0, cyc, to);
    total++;
    if (to !== 1'b0 || out_q.size() - o0 !== 2 || ks_blk - k0 !== 1) begin
      bad++; $display("FAIL rstmid_rerun got=%0b/%0d/%0d want=0/2/1", to, out_q.size() - o0, ks_blk - k0);
    end else begin
      e0 = in_beat(0) ^ lane_val(0, 0);
      e1 = in_beat(1) ^ lane_val(0, 1);
      total++;
      if (out_q[o0] !== {e0, 16'hFFFF} || out_q[o0 + 1] !== {e1, 16'hFFFF}) begin
        bad++; $display("FAIL rstmid_data_rerun got=%h want=%h", out_q[o0], {e0, 16'hFFFF});
      end
    end
    total++;
    if (len_q[len_q.size() - 1] !== {64'd32, 64'd0}) begin
      bad++; $display("FAIL rstmid_len got=%h want=%h", len_q[len_q.size() - 1], {64'd32, 64'd0});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total         = 0;
    bad           = 0;
    ks_blk        = 0;
    ks_base       = 0;
    done_cnt      = 0;
    ks_auto       = 1'b1;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.aad_bytes = '0;
    bus.pld_bytes = '0;
    bus.dec       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.aad_ready = 1'b1;
    bus.pld_ready = 1'b1;
    bus.len_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_long();
    test_short();
    test_zero();
    test_dec();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
